// File: rtl/cmp_seq_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
// Used by serial_magnitude_compare (optional macro EARLY_EXIT_EN lives in the top).
package cmp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int slices(input int width);
    return width / 2;
  endfunction

  // Width of the slice index; never below one bit so WIDTH=2 still has a k register.
  function automatic int slice_idx_w(input int width);
    int w;
    w = $clog2(width / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/two_bit_slice_cmp.sv
// Combinational 2-bit unsigned slice comparator feeding the serial sequencer.
module two_bit_slice_cmp (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic       gt_o,
  output logic       lt_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);

endmodule

// File: rtl/serial_magnitude_compare.sv
// Sequences one 2-bit slice comparator over WIDTH-bit operands, MSB slice first.
// Optional macro EARLY_EXIT_EN: finish as soon as the first differing slice is seen.
module serial_magnitude_compare
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agrb,
  output logic             aeqb,
  output logic             altb
);

  localparam int NSL   = slices(WIDTH);
  localparam int IDX_W = slice_idx_w(WIDTH);
  localparam logic [IDX_W-1:0] K_TOP  = IDX_W'(NSL - 1);
  localparam logic [IDX_W-1:0] K_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] K_ONE  = IDX_W'(1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_magnitude_compare: WIDTH must be even and >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             decided_q, decided_d;
  logic             gt_q, gt_d, lt_q, lt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             agrb_q, agrb_d, aeqb_q, aeqb_d, altb_q, altb_d;
  logic [1:0]       a_sl_s, b_sl_s;
  logic             sl_gt_s, sl_lt_s;
  logic             last_s, exit_s;

  if (NSL == 1) begin : g_one_slice
    assign a_sl_s = a_q[1:0];
    assign b_sl_s = b_q[1:0];
  end else begin : g_mux_slice
    assign a_sl_s = a_q[{k_q, 1'b0} +: 2];
    assign b_sl_s = b_q[{k_q, 1'b0} +: 2];
  end

  two_bit_slice_cmp u_slice (
    .a_i  (a_sl_s),
    .b_i  (b_sl_s),
    .gt_o (sl_gt_s),
    .lt_o (sl_lt_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    agrb_d    = agrb_q;
    aeqb_d    = aeqb_q;
    altb_d    = altb_q;
    last_s    = 1'b0;
    exit_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          k_d       = K_TOP;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Only the first differing slice (from the MSB end) decides the result.
        if (!decided_q && sl_gt_s) begin
          gt_d      = 1'b1;
          decided_d = 1'b1;
        end else if (!decided_q && sl_lt_s) begin
          lt_d      = 1'b1;
          decided_d = 1'b1;
        end else begin
          decided_d = decided_q;
        end

        last_s = (k_q == K_ZERO);
        if (last_s) begin
          k_d = K_ZERO;
        end else begin
          k_d = k_q - K_ONE;
        end

`ifdef EARLY_EXIT_EN
        exit_s = last_s | (decided_d & ~decided_q);
`else
        exit_s = last_s;
`endif

        if (exit_s) begin
          state_d = DONE;
          agrb_d  = gt_d;
          altb_d  = lt_d;
          aeqb_d  = ~gt_d & ~lt_d;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset discards any in-flight compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      k_q       <= K_ZERO;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      agrb_q    <= 1'b0;
      aeqb_q    <= 1'b0;
      altb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      k_q       <= k_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      agrb_q    <= agrb_d;
      aeqb_q    <= aeqb_d;
      altb_q    <= altb_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign agrb = agrb_q;
  assign aeqb = aeqb_q;
  assign altb = altb_q;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Self-checking bench: WIDTH=8 and WIDTH=2 instances against a transaction-level model.
module tb_serial_magnitude_compare;

  logic       clk;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, done8, agrb8, aeqb8, altb8;
  logic       busy2, done2, agrb2, aeqb2, altb2;

  int checks = 0;
  int errors = 0;

`ifdef EARLY_EXIT_EN
  localparam int LAT_B4 = 3;
  localparam int LAT_00 = 1;
`else
  localparam int LAT_B4 = 4;
  localparam int LAT_00 = 4;
`endif

  serial_magnitude_compare #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .agrb(agrb8), .aeqb(aeqb8), .altb(altb8)
  );

  serial_magnitude_compare #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .agrb(agrb2), .aeqb(aeqb2), .altb(altb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Cycles from acceptance to done: slices examined until the result is known.
  function automatic int ref_lat(input int w, input logic [31:0] a, input logic [31:0] b);
`ifdef EARLY_EXIT_EN
    for (int j = 1; j <= w / 2; j++) begin
      if (((a >> (w - 2 * j)) & 32'd3) != ((b >> (w - 2 * j)) & 32'd3)) return j;
    end
`endif
    return w / 2;
  endfunction

  function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b);
    return {a > b, a == b, a < b};
  endfunction

  // Transaction model: m_cnt = busy cycles left; done on the last one.
  int         m_cnt [2];
  logic [2:0] m_res [2];
  logic [2:0] m_pend[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i]  <= 0;
        m_res[i]  <= 3'b000;
        m_pend[i] <= 3'b000;
      end
    end else begin
      if (m_cnt[0] == 0) begin
        if (start8) begin
          m_cnt[0]  <= ref_lat(8, 32'(a8), 32'(b8)) + 1;
          m_pend[0] <= ref_res(32'(a8), 32'(b8));
        end
      end else begin
        if (m_cnt[0] == 2) m_res[0] <= m_pend[0];
        m_cnt[0] <= m_cnt[0] - 1;
      end
      if (m_cnt[1] == 0) begin
        if (start2) begin
          m_cnt[1]  <= ref_lat(2, 32'(a2), 32'(b2)) + 1;
          m_pend[1] <= ref_res(32'(a2), 32'(b2));
        end
      end else begin
        if (m_cnt[1] == 2) m_res[1] <= m_pend[1];
        m_cnt[1] <= m_cnt[1] - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy8", 32'(busy8), 32'(m_cnt[0] != 0));
    chk("done8", 32'(done8), 32'(m_cnt[0] == 1));
    chk("res8", 32'({agrb8, aeqb8, altb8}), 32'(m_res[0]));
    chk("busy2", 32'(busy2), 32'(m_cnt[1] != 0));
    chk("done2", 32'(done2), 32'(m_cnt[1] == 1));
    chk("res2", 32'({agrb2, aeqb2, altb2}), 32'(m_res[1]));
  end

  // Called on a falling edge; when poke is set, start stays high with fresh operands throughout.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp_res,
                      input int exp_lat, input bit poke, input string nm);
    int n;
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = poke; n = 0;
    while (!done8 && n < 20) begin
      if (poke) begin a8 = 8'($urandom); b8 = 8'($urandom); end
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 32'(done8), 32'd1);
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
    chk({nm, "_res"}, 32'({agrb8, aeqb8, altb8}), 32'(exp_res));
    if (poke) begin
      @(negedge clk);
      chk({nm, "_no_second_done"}, 32'(done8), 32'd0);
      start8 = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      chk({nm, "_single_done"}, 32'(done8), 32'd0);
    end
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b);
    int n;
    a2 = a; b2 = b; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; n = 0;
    while (!done2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("w2_lat", 32'(n), 32'd1);
    chk("w2_res", 32'({agrb2, aeqb2, altb2}), 32'({a > b, a == b, a < b}));
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] mask;
    rst_n = 1'b1; start8 = 1'b0; start2 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a2 = 2'b00; b2 = 2'b00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs8", 32'({busy8, done8, agrb8, aeqb8, altb8}), 32'd0);
    chk("reset_outs2", 32'({busy2, done2, agrb2, aeqb2, altb2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'hB4, 8'hB1, 3'b100, LAT_B4, 1'b0, "b4_b1");
    run8(8'h5A, 8'h5A, 3'b010, 4, 1'b0, "eq_5a");
    run8(8'h00, 8'hC0, 3'b001, LAT_00, 1'b0, "00_c0");
    run8(8'h5A, 8'h5A, 3'b010, 4, 1'b1, "start_ignored");

    // Reset in the second RUN cycle of a full-length compare.
    a8 = 8'h5A; b8 = 8'h5B; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midrun_reset_outs", 32'({busy8, done8, agrb8, aeqb8, altb8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrun_no_done", 32'(done8), 32'd0);
    end
    run8(8'h5A, 8'h5B, 3'b001, 4, 1'b0, "after_reset");

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        run2(2'(i), 2'(j));
      end
    end

    // Random back-to-back traffic; operands often share their upper slices.
    repeat (3000) begin
      start8 = ($urandom_range(0, 2) == 0);
      a8 = 8'($urandom);
      case ($urandom_range(0, 3))
        0: mask = 8'hFF;
        1: mask = 8'h0F;
        2: mask = 8'h03;
        default: mask = 8'h00;
      endcase
      b8 = a8 ^ (8'($urandom) & mask);
      start2 = ($urandom_range(0, 1) == 0);
      a2 = 2'($urandom);
      b2 = 2'($urandom);
      @(negedge clk);
    end
    start8 = 1'b0; start2 = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
